booth4_op_sequencer: RTL and testbench

Upstream feeder and downstream collector for the 4-bit Booth multiplier (`Booth_4bit`: `en`, `A`, `B`, `Prod`, `done`). It accepts operand pairs through a valid/ready port and buffers them in a small FIFO. Each pair is issued to the multiplier using the en-high-until-done / en-low-gap protocol, and each product is returned through a valid/ready result port. A run that never completes is cut off by a watchdog and reported as an error.

---
 rtl/booth4_op_sequencer.sv | 133 +++++++++++++
 tb/tb_booth4_op_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/booth4_op_sequencer.sv
// booth4_op_sequencer: buffers operand pairs, issues them to a 4-bit Booth multiplier
// with the en-high-until-done / en-low-gap protocol, and returns products through a result slot.
module booth4_op_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 63
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    output logic       mul_en,
    output logic [3:0] mul_a,
    output logic [3:0] mul_b,
    input  logic [7:0] mul_prod,
    input  logic       mul_done,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_prod,
    output logic       out_err,
    output logic       busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GC_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q;
    state_t        state_q, state_d;
    logic [WW-1:0] wd_q, wd_d;
    logic [GW-1:0] gc_q, gc_d;
    logic          en_q, en_d, ov_q, ov_d, err_q, err_d;
    logic [3:0]    a_q, a_d, b_q, b_d;
    logic [7:0]    prod_q, prod_d;
    logic          push, launch;

    assign in_ready  = cnt_q != (AW+1)'(FIFO_DEPTH);
    assign push      = in_valid && in_ready;
    // Launch only into an empty result slot, so a capture can never overwrite a pending result.
    assign launch    = (state_q == IDLE) && (cnt_q != '0) && !ov_q;
    assign mul_en    = en_q;
    assign mul_a     = a_q;
    assign mul_b     = b_q;
    assign out_valid = ov_q;
    assign out_prod  = prod_q;
    assign out_err   = err_q;
    assign busy      = (cnt_q != '0) || (state_q != IDLE) || ov_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wp_q] <= {in_a, in_b};
                wp_q        <= wp_q + AW'(1);
            end
            if (launch)
                rp_q <= rp_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(launch);
        end
    end

    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        gc_d    = gc_q;
        en_d    = en_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        err_d   = err_q;
        ov_d    = (ov_q && out_ready) ? 1'b0 : ov_q;
        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d    = RUN;
                    en_d       = 1'b1;
                    {a_d, b_d} = mem_q[rp_q];
                    wd_d       = '0;
                end
            end
            RUN: begin
                wd_d = wd_q + WW'(1);
                if (mul_done || wd_q == WD_LAST) begin
                    prod_d  = mul_done ? mul_prod : 8'h00;
                    err_d   = !mul_done;
                    ov_d    = 1'b1;
                    en_d    = 1'b0;
                    gc_d    = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                gc_d    = gc_q + GW'(1);
                state_d = (gc_q == GC_LAST) ? IDLE : GAP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wd_q    <= '0;
            gc_q    <= '0;
            en_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            ov_q    <= 1'b0;
            prod_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            gc_q    <= gc_d;
            en_q    <= en_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ov_q    <= ov_d;
            prod_q  <= prod_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_booth4_op_sequencer.sv
// tb_booth4_op_sequencer: directed bench with a behavioural Booth multiplier that answers after 6 cycles.
module tb_booth4_op_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_a = '0, in_b = '0;
    logic       mul_en;
    logic [3:0] mul_a, mul_b;
    logic [7:0] mul_prod;
    logic       mul_done = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_prod;
    logic       out_err;
    logic       busy;

    int n_cmp = 0, n_err = 0;

    booth4_op_sequencer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b),
        .mul_prod(mul_prod), .mul_done(mul_done), .out_valid(out_valid),
        .out_ready(out_ready), .out_prod(out_prod), .out_err(out_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Multiplier model: done pulses so that en is high for exactly 6 cycles.
    logic signed [7:0] sa, sb;
    logic model_on = 1'b1;
    int   mcnt = 0;
    assign sa = {{4{mul_a[3]}}, mul_a};
    assign sb = {{4{mul_b[3]}}, mul_b};
    assign mul_prod = sa * sb;
    always @(posedge clk) begin
        if (!mul_en) begin
            mcnt     <= 0;
            mul_done <= 1'b0;
        end else begin
            mcnt     <= mcnt + 1;
            mul_done <= model_on && (mcnt == 4);
        end
    end

    // Enable waveform monitor: high-run length, shortest low gap before a rise, rise count.
    int   hi_cnt = 0, lo_cnt = 1000, last_high = 0, min_low = 1000, rises = 0;
    logic prev_en = 1'b0, mon_clr = 1'b0;
    always @(negedge clk) begin
        if (mon_clr) min_low <= 1000;
        if (mul_en) begin
            if (!prev_en) begin
                rises  <= rises + 1;
                hi_cnt <= 1;
                if (!mon_clr && lo_cnt < min_low) min_low <= lo_cnt;
            end else hi_cnt <= hi_cnt + 1;
            lo_cnt <= 0;
        end else begin
            if (prev_en) last_high <= hi_cnt;
            lo_cnt <= lo_cnt + 1;
        end
        prev_en <= mul_en;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] a, input logic [3:0] b);
        logic ok;
        int   n = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        do begin
            ok = in_ready;
            step(1);
            n++;
        end while (!ok && n < 300);
        if (!ok) chk("push_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic get_result(input string tag, input logic [7:0] ep, input logic ee);
        int n = 0;
        while (!out_valid && n < 300) begin
            step(1);
            n++;
        end
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_prod"}, out_prod, ep);
        chk({tag, "_err"}, out_err, ee);
        step(1);
    endtask

    task automatic clr_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
        step(1);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1);
    end

    int r0;
    initial begin
        step(3);
        rst = 1'b0;
        chk("rst_mul_en", mul_en, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_mul_b", mul_b, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_prod", out_prod, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);

        // Single op: 2*2, launch latency one cycle after the push edge.
        push(4'h2, 4'h2);
        chk("lat_en_low", mul_en, 0);
        chk("lat_busy", busy, 1);
        step(1);
        chk("lat_en_high", mul_en, 1);
        chk("lat_mul_a", mul_a, 4'h2);
        chk("lat_mul_b", mul_b, 4'h2);
        get_result("p22", 8'h04, 1'b0);
        chk("p22_en_len", last_high, 6);
        step(3);
        chk("p22_idle_en", mul_en, 0);
        chk("p22_idle_busy", busy, 0);

        // Back-to-back issue: 3 ops, gap between en pulses is GAP_CYCLES+1.
        clr_mon();
        push(4'h3, 4'h4);
        push(4'h1, 4'h3);
        push(4'h4, 4'h2);
        get_result("p34", 8'h0C, 1'b0);
        get_result("p13", 8'h03, 1'b0);
        get_result("p42", 8'h08, 1'b0);
        step(1);
        chk("b2b_min_gap", min_low, 3);
        chk("b2b_en_len", last_high, 6);

        // Signed operands.
        push(4'hD, 4'h2);
        push(4'h8, 4'h8);
        get_result("pm32", 8'hFA, 1'b0);
        get_result("pm8m8", 8'h40, 1'b0);

        // Backpressure: one result held, FIFO fills, no relaunch.
        step(5);
        out_ready = 1'b0;
        r0 = rises;
        push(4'h1, 4'h1);
        push(4'h2, 4'h3);
        push(4'hF, 4'h5);
        push(4'h7, 4'h7);
        push(4'h7, 4'hF);
        chk("bp_in_ready_full", in_ready, 0);
        step(20);
        chk("bp_held_valid", out_valid, 1);
        chk("bp_held_prod", out_prod, 8'h01);
        chk("bp_one_launch", rises, r0 + 1);
        chk("bp_en_low", mul_en, 0);
        chk("bp_in_ready_still", in_ready, 0);
        out_ready = 1'b1;
        get_result("bp0", 8'h01, 1'b0);
        get_result("bp1", 8'h06, 1'b0);
        get_result("bp2", 8'hFB, 1'b0);
        get_result("bp3", 8'h31, 1'b0);
        get_result("bp4", 8'hF9, 1'b0);
        chk("bp_drained_ready", in_ready, 1);

        // Watchdog: multiplier never answers.
        step(5);
        model_on = 1'b0;
        push(4'h3, 4'h3);
        get_result("wd", 8'h00, 1'b1);
        model_on = 1'b1;
        chk("wd_en_len", last_high, 63);
        push(4'h5, 4'h3);
        get_result("wd_next", 8'h0F, 1'b0);

        // Reset mid-RUN with 3 entries queued.
        step(5);
        push(4'h2, 4'h5);
        push(4'h3, 4'h5);
        push(4'h4, 4'h5);
        push(4'h6, 4'h5);
        chk("mr_in_run", mul_en, 1);
        r0 = rises;
        rst = 1'b1;
        step(1);
        chk("mr_en", mul_en, 0);
        chk("mr_busy", busy, 0);
        chk("mr_in_ready", in_ready, 1);
        chk("mr_out_valid", out_valid, 0);
        rst = 1'b0;
        step(15);
        chk("mr_no_result", out_valid, 0);
        chk("mr_no_relaunch", rises, r0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
